game_round_ctrl: RTL

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

---
 rtl/game_round_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/game_round_ctrl.sv
// Round sequencer for the duck-shoot game: start/play/reload/over flow,
// magazine and score bookkeeping, and the per-second round countdown.
module game_round_ctrl #(
  parameter int TICKS_PER_SEC = 25000000,
  parameter int ROUND_SECS    = 30,
  parameter int MAG_SIZE      = 4,
  parameter int RELOAD_CYCLES = 12500000
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       fire,
  input  logic       reload,
  input  logic       hit,
  output logic       run,
  output logic       fire_pulse,
  output logic [2:0] bullets,
  output logic [7:0] score,
  output logic [4:0] secs_left,
  output logic [1:0] state
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int RW = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);
  localparam logic [RW-1:0] RLD_MAX  = RW'(RELOAD_CYCLES - 1);
  localparam logic [2:0]    MAG      = 3'(MAG_SIZE);
  localparam logic [4:0]    SECS     = 5'(ROUND_SECS);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_RELOAD, S_OVER} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [RW-1:0]   rld_q, rld_d;
  logic [2:0]      bullets_q, bullets_d;
  logic [7:0]      score_q, score_d;
  logic [4:0]      secs_q, secs_d;
  logic            pulse_q, pulse_d;
  logic            fire_q, hit_q;

  logic fire_edge, hit_edge, sec_tick, expire, fire_ok, rld_done, start_ok;

  assign fire_edge = fire & ~fire_q;
  assign hit_edge  = hit & ~hit_q;
  assign run       = (state_q == S_PLAY) || (state_q == S_RELOAD);
  assign sec_tick  = run && (tick_q == TICK_MAX);
  // Expiry wins over every other transition taken on the same edge.
  assign expire    = sec_tick && (secs_q == 5'd1);
  assign fire_ok   = (state_q == S_PLAY) && fire_edge && (bullets_q != 3'd0) && !expire;
  assign rld_done  = (state_q == S_RELOAD) && (rld_q == RLD_MAX);
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_OVER));

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      rld_q     <= '0;
      bullets_q <= MAG;
      score_q   <= '0;
      secs_q    <= SECS;
      pulse_q   <= 1'b0;
      fire_q    <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      rld_q     <= rld_d;
      bullets_q <= bullets_d;
      score_q   <= score_d;
      secs_q    <= secs_d;
      pulse_q   <= pulse_d;
      fire_q    <= fire;
      hit_q     <= hit;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_OVER: if (start) state_d = S_PLAY;
      S_PLAY:         if (expire) state_d = S_OVER;
                      else if (reload) state_d = S_RELOAD;
      S_RELOAD:       if (expire) state_d = S_OVER;
                      else if (rld_done) state_d = S_PLAY;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick_d    = tick_q;
    rld_d     = rld_q;
    bullets_d = bullets_q;
    score_d   = score_q;
    secs_d    = secs_q;
    pulse_d   = 1'b0;
    if (start_ok) begin
      tick_d    = '0;
      rld_d     = '0;
      bullets_d = MAG;
      score_d   = '0;
      secs_d    = SECS;
    end
    if (run) begin
      tick_d = sec_tick ? '0 : tick_q + 1'b1;
      if (sec_tick) secs_d = secs_q - 5'd1;
      if (hit_edge && (score_q != 8'hFF)) score_d = score_q + 8'd1;
    end
    if (fire_ok) begin
      pulse_d   = 1'b1;
      bullets_d = bullets_q - 3'd1;
    end
    if (state_q == S_PLAY) rld_d = '0;
    if (state_q == S_RELOAD) begin
      rld_d = rld_q + 1'b1;
      if (rld_done) begin
        rld_d = '0;
        if (!expire) bullets_d = MAG;
      end
    end
  end

  assign fire_pulse = pulse_q;
  assign bullets    = bullets_q;
  assign score      = score_q;
  assign secs_left  = secs_q;
  assign state      = state_q;

endmodule
